// File: rtl/row_pkt_pkg.sv
// Shared constants, FSM state encoding and a saturating-increment helper
// for the row packet receiver.
package row_pkt_pkg;

  localparam int ROW_DATA_W               = 512;
  localparam int DEFAULT_BEATS_PER_PACKET = 32;
  localparam int SAT_CNT_W                = 16;

  typedef logic [1:0] row_state_t;

  localparam row_state_t ST_HEADER = 2'd0;
  localparam row_state_t ST_DATA   = 2'd1;
  localparam row_state_t ST_FOOTER = 2'd2;

  function automatic logic [SAT_CNT_W-1:0] sat_inc(input logic [SAT_CNT_W-1:0] v);
    return (v == '1) ? v : v + SAT_CNT_W'(1);
  endfunction

endpackage

// File: rtl/axis_out_stage.sv
// One-entry registered AXI-Stream output. The upstream may load only when
// the register is empty or being drained, so TDATA never changes under a stall.
module axis_out_stage #(
  parameter int DATA_W = 512
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_tready,
  output logic [DATA_W-1:0] o_tdata,
  output logic              o_tvalid,
  output logic              o_up_ready
);

  logic [DATA_W-1:0] r_tdata;
  logic              r_tvalid;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tdata  <= '0;
      r_tvalid <= 1'b0;
    end else if (i_load) begin
      r_tdata  <= i_data;
      r_tvalid <= 1'b1;
    end else if (i_tready) begin
      r_tvalid <= 1'b0;
    end
  end

  assign o_up_ready = !r_tvalid || i_tready;
  assign o_tdata    = r_tdata;
  assign o_tvalid   = r_tvalid;

endmodule

// File: rtl/row_packet_rx.sv
// Row packet receiver: strips header/footer, forwards payload, reports status.
// Optional header sequence checking is enabled by ROW_PKT_SEQ_CHECK_EN.
module row_packet_rx
  import row_pkt_pkg::*;
#(
  parameter int REQ_ID_WIDTH     = 32,
  parameter int BEATS_PER_PACKET = DEFAULT_BEATS_PER_PACKET
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ROW_DATA_W-1:0]   AXIS_RX_TDATA,
  input  logic                    AXIS_RX_TVALID,
  output logic                    AXIS_RX_TREADY,
  output logic [ROW_DATA_W-1:0]   AXIS_TX_TDATA,
  output logic                    AXIS_TX_TVALID,
  input  logic                    AXIS_TX_TREADY,
  output logic                    PKT_DONE,
  output logic [REQ_ID_WIDTH-1:0] PKT_REQ_ID,
  output logic                    PKT_ERR,
  output logic [31:0]             PKT_COUNT,
  output logic [SAT_CNT_W-1:0]    ERR_COUNT,
  output row_state_t              DBG_STATE
`ifdef ROW_PKT_SEQ_CHECK_EN
  ,
  output logic                    SEQ_ERR,
  output logic [SAT_CNT_W-1:0]    SEQ_ERR_COUNT
`endif
);

  // Handshake rule on both ports: a beat transfers on a rising clk edge
  // where TVALID and TREADY are both high; TVALID never depends on TREADY.

  row_state_t              r_state;
  logic [REQ_ID_WIDTH-1:0] r_hdr_id;
  logic [7:0]              r_beat_cnt;
  logic                    r_done;
  logic [REQ_ID_WIDTH-1:0] r_req_id;
  logic                    r_err;
  logic [31:0]             r_pkt_count;
  logic [SAT_CNT_W-1:0]    r_err_count;

  logic w_rx_hs;
  logic w_load;
  logic w_up_ready;
  logic w_id_match;

  always_comb begin
    AXIS_RX_TREADY = 1'b0;
    if (!reset) begin
      AXIS_RX_TREADY = (r_state == ST_DATA) ? w_up_ready : 1'b1;
    end
  end

  assign w_rx_hs    = AXIS_RX_TVALID && AXIS_RX_TREADY;
  assign w_load     = w_rx_hs && (r_state == ST_DATA);
  assign w_id_match = (AXIS_RX_TDATA[REQ_ID_WIDTH-1:0] == r_hdr_id);

  axis_out_stage #(.DATA_W(ROW_DATA_W)) u_out (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_load),
    .i_data     (AXIS_RX_TDATA),
    .i_tready   (AXIS_TX_TREADY),
    .o_tdata    (AXIS_TX_TDATA),
    .o_tvalid   (AXIS_TX_TVALID),
    .o_up_ready (w_up_ready)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_HEADER;
      r_hdr_id    <= '0;
      r_beat_cnt  <= '0;
      r_done      <= 1'b0;
      r_req_id    <= '0;
      r_err       <= 1'b0;
      r_pkt_count <= '0;
      r_err_count <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_HEADER: if (w_rx_hs) begin
          r_hdr_id   <= AXIS_RX_TDATA[REQ_ID_WIDTH-1:0];
          r_beat_cnt <= 8'(BEATS_PER_PACKET);
          r_state    <= ST_DATA;
        end
        ST_DATA: if (w_rx_hs) begin
          r_beat_cnt <= r_beat_cnt - 8'd1;
          if (r_beat_cnt == 8'd1) r_state <= ST_FOOTER;
        end
        ST_FOOTER: if (w_rx_hs) begin
          // Status and counters become visible together with the PKT_DONE strobe.
          r_done      <= 1'b1;
          r_req_id    <= r_hdr_id;
          r_err       <= !w_id_match;
          r_pkt_count <= r_pkt_count + 32'd1;
          if (!w_id_match) r_err_count <= sat_inc(r_err_count);
          r_state     <= ST_HEADER;
        end
        default: r_state <= ST_HEADER;
      endcase
    end
  end

  assign PKT_DONE   = r_done;
  assign PKT_REQ_ID = r_req_id;
  assign PKT_ERR    = r_err;
  assign PKT_COUNT  = r_pkt_count;
  assign ERR_COUNT  = r_err_count;
  assign DBG_STATE  = r_state;

`ifdef ROW_PKT_SEQ_CHECK_EN
  logic                    r_seq_seeded;
  logic                    r_hdr_seq_bad;
  logic                    r_seq_err;
  logic [REQ_ID_WIDTH-1:0] r_exp_id;
  logic [SAT_CNT_W-1:0]    r_seq_err_count;

  // The header verdict is parked until the footer so it reports with PKT_DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_seq_seeded    <= 1'b0;
      r_hdr_seq_bad   <= 1'b0;
      r_seq_err       <= 1'b0;
      r_exp_id        <= '0;
      r_seq_err_count <= '0;
    end else begin
      if (w_rx_hs && (r_state == ST_HEADER)) begin
        r_hdr_seq_bad <= r_seq_seeded && (AXIS_RX_TDATA[REQ_ID_WIDTH-1:0] != r_exp_id);
        r_exp_id      <= AXIS_RX_TDATA[REQ_ID_WIDTH-1:0] + REQ_ID_WIDTH'(1);
        r_seq_seeded  <= 1'b1;
      end
      if (w_rx_hs && (r_state == ST_FOOTER)) begin
        r_seq_err <= r_hdr_seq_bad;
        if (r_hdr_seq_bad) r_seq_err_count <= sat_inc(r_seq_err_count);
      end
    end
  end

  assign SEQ_ERR       = r_seq_err;
  assign SEQ_ERR_COUNT = r_seq_err_count;
`endif

endmodule

// File: tb/tb_row_packet_rx.sv
// Directed bench for row_packet_rx: framing, mismatch, backpressure,
// mid-packet reset, error counter saturation and optional sequence check.
module tb_row_packet_rx;
  import row_pkt_pkg::*;

  localparam int IDW = 32;
  localparam int BPP = 32;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [511:0]   AXIS_RX_TDATA = '0;
  logic           AXIS_RX_TVALID = 1'b0;
  logic           AXIS_RX_TREADY;
  logic [511:0]   AXIS_TX_TDATA;
  logic           AXIS_TX_TVALID;
  logic           AXIS_TX_TREADY = 1'b1;
  logic           PKT_DONE;
  logic [IDW-1:0] PKT_REQ_ID;
  logic           PKT_ERR;
  logic [31:0]    PKT_COUNT;
  logic [15:0]    ERR_COUNT;
  row_state_t     DBG_STATE;
`ifdef ROW_PKT_SEQ_CHECK_EN
  logic           SEQ_ERR;
  logic [15:0]    SEQ_ERR_COUNT;
`endif

  row_packet_rx #(.REQ_ID_WIDTH(IDW), .BEATS_PER_PACKET(BPP)) dut (
    .clk            (clk),
    .reset          (reset),
    .AXIS_RX_TDATA  (AXIS_RX_TDATA),
    .AXIS_RX_TVALID (AXIS_RX_TVALID),
    .AXIS_RX_TREADY (AXIS_RX_TREADY),
    .AXIS_TX_TDATA  (AXIS_TX_TDATA),
    .AXIS_TX_TVALID (AXIS_TX_TVALID),
    .AXIS_TX_TREADY (AXIS_TX_TREADY),
    .PKT_DONE       (PKT_DONE),
    .PKT_REQ_ID     (PKT_REQ_ID),
    .PKT_ERR        (PKT_ERR),
    .PKT_COUNT      (PKT_COUNT),
    .ERR_COUNT      (ERR_COUNT),
    .DBG_STATE      (DBG_STATE)
`ifdef ROW_PKT_SEQ_CHECK_EN
    ,
    .SEQ_ERR        (SEQ_ERR),
    .SEQ_ERR_COUNT  (SEQ_ERR_COUNT)
`endif
  );

  int total = 0;
  int bad   = 0;
  logic [511:0] exp_q[$];
  logic [32:0]  exp_done_q[$];
  bit tx_rand = 1'b0;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic send_beat(input logic [511:0] d, output int stalls);
    int n;
    n = 0;
    @(negedge clk);
    AXIS_RX_TDATA  = d;
    AXIS_RX_TVALID = 1'b1;
    #1;
    while (!AXIS_RX_TREADY && n < 500) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 500) chk("rx_ready_timeout", AXIS_RX_TREADY, 1);
    stalls = n;
  endtask

  task automatic rand_upper(output logic [511:0] d);
    for (int i = 0; i < 16; i++) d[i*32 +: 32] = $urandom;
  endtask

  task automatic send_header(input logic [31:0] hid, output int stalls);
    logic [511:0] d;
    rand_upper(d);
    d[31:0] = hid;
    send_beat(d, stalls);
  endtask

  task automatic send_payload(input logic [31:0] hid, input int base, input int nbeats,
                              output int stalls);
    logic [511:0] d;
    int s;
    stalls = 0;
    for (int i = 0; i < nbeats; i++) begin
      d = 512'(base + i) | (512'(hid) << 256);
      exp_q.push_back(d);
      send_beat(d, s);
      stalls += s;
    end
  endtask

  task automatic send_packet(input logic [31:0] hid, input logic [31:0] fid, input int base,
                             output int stalls);
    logic [511:0] d;
    int s;
    send_header(hid, s);
    stalls = s;
    send_payload(hid, base, BPP, s);
    stalls += s;
    rand_upper(d);
    d[31:0] = fid;
    exp_done_q.push_back({hid != fid, hid});
    send_beat(d, s);
    stalls += s;
  endtask

  task automatic rx_stop();
    @(negedge clk);
    AXIS_RX_TVALID = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || exp_done_q.size() != 0) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_tx_left"}, exp_q.size(), 0);
    chk({tag, "_done_left"}, exp_done_q.size(), 0);
  endtask

  // TX ready generator
  initial begin
    forever begin
      @(negedge clk);
      AXIS_TX_TREADY = tx_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // scoreboard: payload order, stall stability, completion reports
  initial begin
    logic         prev_stall;
    logic [511:0] prev_data;
    logic [32:0]  e;
    prev_stall = 1'b0;
    prev_data  = '0;
    forever begin
      @(negedge clk);
      #2;
      if (prev_stall) begin
        chk("tx_hold_valid", AXIS_TX_TVALID, 1);
        chk("tx_hold_data", AXIS_TX_TDATA, prev_data);
      end
      if (AXIS_TX_TVALID === 1'b1 && AXIS_TX_TREADY === 1'b1) begin
        if (exp_q.size() == 0) chk("tx_extra_beat", AXIS_TX_TVALID, 0);
        else chk("tx_data", AXIS_TX_TDATA, exp_q.pop_front());
      end
      if (PKT_DONE === 1'b1) begin
        if (exp_done_q.size() == 0) chk("done_unexpected", PKT_DONE, 0);
        else begin
          e = exp_done_q.pop_front();
          chk("done_id", PKT_REQ_ID, e[31:0]);
          chk("done_err", PKT_ERR, e[32]);
        end
      end
      prev_stall = (AXIS_TX_TVALID === 1'b1) && (AXIS_TX_TREADY === 1'b0);
      prev_data  = AXIS_TX_TDATA;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // directed steps
  initial begin : main
    int s;

    // reset values
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_rx_ready", AXIS_RX_TREADY, 0);
    chk("rst_tx_valid", AXIS_TX_TVALID, 0);
    chk("rst_tx_data", AXIS_TX_TDATA, 0);
    chk("rst_done", PKT_DONE, 0);
    chk("rst_err", PKT_ERR, 0);
    chk("rst_req_id", PKT_REQ_ID, 0);
    chk("rst_pkt_count", PKT_COUNT, 0);
    chk("rst_err_count", ERR_COUNT, 0);
    reset = 1'b0;
    #1;
    chk("post_rst_rx_ready", AXIS_RX_TREADY, 1);
    chk("post_rst_state", DBG_STATE, ST_HEADER);

    // single good packet, full throughput
    send_packet(32'h1234, 32'h1234, 0, s);
    chk("p1_stalls", s, 0);
    rx_stop();
    chk("p1_done", PKT_DONE, 1);
    chk("p1_req_id", PKT_REQ_ID, 32'h1234);
    chk("p1_err", PKT_ERR, 0);
    chk("p1_pkt_count", PKT_COUNT, 1);
    chk("p1_state", DBG_STATE, ST_HEADER);
    @(negedge clk);
    chk("p1_done_strobe", PKT_DONE, 0);
    wait_drain("p1");

    // footer mismatch
    send_packet(32'h5, 32'h6, 100, s);
    rx_stop();
    chk("p2_done", PKT_DONE, 1);
    chk("p2_err", PKT_ERR, 1);
    chk("p2_req_id", PKT_REQ_ID, 32'h5);
    chk("p2_err_count", ERR_COUNT, 1);
    chk("p2_pkt_count", PKT_COUNT, 2);
    wait_drain("p2");

    // random TX backpressure, back-to-back packets
    tx_rand = 1'b1;
    send_packet(32'h7, 32'h7, 200, s);
    send_packet(32'h8, 32'h8, 300, s);
    send_packet(32'h9, 32'h9, 400, s);
    rx_stop();
    wait_drain("bp");
    tx_rand = 1'b0;
    chk("bp_pkt_count", PKT_COUNT, 5);
    chk("bp_err_count", ERR_COUNT, 1);

    // reset after 10 payload beats
    send_header(32'h20, s);
    send_payload(32'h20, 500, 10, s);
    @(negedge clk);
    AXIS_RX_TVALID = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_tx_valid", AXIS_TX_TVALID, 0);
    chk("mid_rst_pkt_count", PKT_COUNT, 0);
    chk("mid_rst_err_count", ERR_COUNT, 0);
    chk("mid_rst_rx_ready", AXIS_RX_TREADY, 0);
    chk("mid_rst_state", DBG_STATE, ST_HEADER);
    reset = 1'b0;
    #1;
    chk("mid_rst_rx_ready_after", AXIS_RX_TREADY, 1);
    chk("mid_rst_tx_left", exp_q.size(), 0);
    send_packet(32'h9, 32'h9, 600, s);
    rx_stop();
    chk("p9_done", PKT_DONE, 1);
    chk("p9_req_id", PKT_REQ_ID, 32'h9);
    chk("p9_pkt_count", PKT_COUNT, 1);
    wait_drain("p9");

    // error counter saturation
    @(negedge clk);
    force dut.r_err_count = 16'hFFFE;
    @(negedge clk);
    release dut.r_err_count;
    @(negedge clk);
    chk("sat_preload", ERR_COUNT, 16'hFFFE);
    send_packet(32'h30, 32'h31, 700, s);
    rx_stop();
    chk("sat_first", ERR_COUNT, 16'hFFFF);
    send_packet(32'h32, 32'h33, 800, s);
    rx_stop();
    chk("sat_hold", ERR_COUNT, 16'hFFFF);
    chk("sat_pkt_count", PKT_COUNT, 3);
    wait_drain("sat");

`ifdef ROW_PKT_SEQ_CHECK_EN
    // header sequence checking: 10, 11, 13
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    send_packet(32'd10, 32'd10, 0, s);
    rx_stop();
    chk("seq_10", SEQ_ERR, 0);
    chk("seq_10_perr", PKT_ERR, 0);
    send_packet(32'd11, 32'd11, 50, s);
    rx_stop();
    chk("seq_11", SEQ_ERR, 0);
    chk("seq_11_perr", PKT_ERR, 0);
    send_packet(32'd13, 32'd13, 90, s);
    rx_stop();
    chk("seq_13", SEQ_ERR, 1);
    chk("seq_13_perr", PKT_ERR, 0);
    chk("seq_count", SEQ_ERR_COUNT, 1);
    chk("seq_err_count", ERR_COUNT, 0);
    wait_drain("seq");
`endif

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
